seq_divider: RTL and testbench
==============================

SEQ_DIVIDER -- requirements
Module: seq_divider

Interface
REQ-001 SHALL have parameter DVD_W, default 16, dividend and quotient width.
REQ-002 SHALL have parameter DVS_W, default 8, divisor and remainder width; DVS_W <= DVD_W.
REQ-003 SHALL have port clock  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port start  input  1  request; sampled only in IDLE.
REQ-006 SHALL have port dividend  input  DVD_W  unsigned dividend, captured on accepted start.
REQ-007 SHALL have port divisor  input  DVS_W  unsigned divisor, captured on accepted start.
REQ-008 SHALL have port busy  output  1  high in RUN and DONE states.
REQ-009 SHALL have port done  output  1  one-cycle pulse; results valid in that cycle.
REQ-010 SHALL have port quotient  output  DVD_W  registered quotient.
REQ-011 SHALL have port remainder  output  DVS_W  registered remainder.
REQ-012 SHALL have port dbz  output  1  divide-by-zero flag, valid with done.

Function
REQ-013 SHALL implement FSM states IDLE, RUN, DONE.
REQ-014 SHALL accept start=1 only in IDLE; at that edge it latches operands, clears the partial remainder, and loads iteration counter with DVD_W-1.
REQ-015 SHALL ignore start while busy=1; no queuing, and latched operands remain unchanged.
REQ-016 SHALL move IDLE->RUN on an accepted start with nonzero divisor.
REQ-017 SHALL move IDLE->DONE directly on an accepted start with divisor==0.
REQ-018 SHALL perform one restoring iteration per RUN cycle, MSB first: R = {R, next dividend bit}; if R >= divisor then R -= divisor and q bit = 1, else q bit = 0.
REQ-019 SHALL hold the partial remainder in DVS_W+1 bits and compute the trial subtraction at DVS_W+1 bits, with no overflow for any operands.
REQ-020 SHALL move RUN->DONE at the edge completing iteration DVD_W, i.e. when the counter equals 0.
REQ-021 SHALL, on normal completion, assert done exactly DVD_W+1 edges after the start edge (17 cycles at defaults).
REQ-022 SHALL, on divisor==0, assert done 1 edge after the start edge, with quotient = all ones, remainder = dividend[DVS_W-1:0], and dbz = 1.
REQ-023 SHALL clear dbz on any non-zero-divisor completion.
REQ-024 SHALL move DONE->IDLE unconditionally after one cycle; done is high only in DONE.
REQ-025 SHALL update quotient, remainder and dbz only on the edge entering DONE, and hold them stable until the next completion.
REQ-026 SHALL accept a start asserted in the cycle after done, allowing back-to-back operations with a one-cycle gap (IDLE).
REQ-027 SHALL keep the exact relation dividend == quotient*divisor + remainder with remainder < divisor for every nonzero divisor.

Reset
REQ-028 SHALL, with reset=1 at an edge, force state IDLE, busy=0, done=0, dbz=0, quotient=0, remainder=0, and clear counter and working registers.
REQ-029 SHALL give reset priority over start and over any in-progress operation; a mid-operation reset discards the operation with no done pulse.
REQ-030 SHALL ignore start on the same edge that reset=1.

Structure
REQ-031 SHALL place the state enum (IDLE/RUN/DONE) and default width constants in package seq_divider_pkg.
REQ-032 SHALL use one combinational sub-module, div_step, that computes one restoring iteration (inputs: partial remainder, dividend bit, divisor; outputs: next remainder, quotient bit).
REQ-033 SHALL keep all registers in seq_divider; div_step is purely combinational.

Verification
REQ-034 SHALL cover: dividend=100, divisor=7 -> done 17 cycles after start; quotient=14, remainder=2, dbz=0.
REQ-035 SHALL cover: dividend=0xFFFF, divisor=0xFF -> quotient=0x0101, remainder=0; then dividend=7, divisor=9 -> quotient=0, remainder=7.
REQ-036 SHALL cover: dividend=0x1234, divisor=0 -> done 1 cycle after start; quotient=0xFFFF, remainder=0x34, dbz=1.
REQ-037 SHALL cover: start pulsed with 50/3 during an ongoing 100/7 RUN -> ignored; only quotient=14, remainder=2 reported, with a single done.
REQ-038 SHALL cover: reset asserted at RUN cycle 8 -> next cycle busy=0, outputs zero, no done; a following start 200/10 -> quotient=20, remainder=0.
REQ-039 SHALL cover: 1000 random nonzero-divisor operations issued back-to-back (start in cycle after done) -> every result satisfies REQ-027, and each done occurs 17 cycles after its start.

Source files
------------

// File: rtl/seq_divider_pkg.sv
// Shared state encoding and default operand widths for the sequential divider.
`default_nettype none

package seq_divider_pkg;

  localparam int DEF_DVD_W = 16;
  localparam int DEF_DVS_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

`default_nettype wire

// File: rtl/div_step.sv
// One restoring-division iteration: shift in a dividend bit, trial-subtract the divisor.
`default_nettype none

module div_step
  import seq_divider_pkg::*;
#(
  parameter int DVS_W = DEF_DVS_W
) (
  input  logic [DVS_W:0]   rem_i,
  input  logic             bit_i,
  input  logic [DVS_W-1:0] divisor_i,
  output logic [DVS_W:0]   rem_o,
  output logic             qbit_o
);

  logic [DVS_W+1:0] shift_w;
  logic [DVS_W+1:0] dvs_w;

  // Widened by one bit so the shifted remainder can never wrap before the compare.
  assign shift_w = {rem_i, bit_i};
  assign dvs_w   = {2'b00, divisor_i};
  assign qbit_o  = (shift_w >= dvs_w);
  assign rem_o   = (DVS_W+1)'(qbit_o ? shift_w - dvs_w : shift_w);

endmodule

`default_nettype wire

// File: rtl/seq_divider.sv
// Multi-cycle unsigned restoring divider: one quotient bit per RUN cycle, MSB first.
`default_nettype none

module seq_divider
  import seq_divider_pkg::*;
#(
  parameter int DVD_W = DEF_DVD_W,
  parameter int DVS_W = DEF_DVS_W
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [DVD_W-1:0] dividend,
  input  logic [DVS_W-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [DVD_W-1:0] quotient,
  output logic [DVS_W-1:0] remainder,
  output logic             dbz
);

  localparam int CNT_W = (DVD_W > 1) ? $clog2(DVD_W) : 1;

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [DVD_W-1:0] dvd_q;
  logic [DVS_W-1:0] dvs_q;
  logic [DVS_W:0]   rem_q;
  logic [DVD_W-1:0] quo_q;
  logic             busy_q;
  logic             done_q;
  logic [DVD_W-1:0] quo_out_q;
  logic [DVS_W-1:0] rem_out_q;
  logic             dbz_q;

  logic [DVS_W:0]   rem_d;
  logic             qbit_d;

  div_step #(.DVS_W(DVS_W)) u_step (
    .rem_i     (rem_q),
    .bit_i     (dvd_q[DVD_W-1]),
    .divisor_i (dvs_q),
    .rem_o     (rem_d),
    .qbit_o    (qbit_d)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      dvd_q     <= '0;
      dvs_q     <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      quo_out_q <= '0;
      rem_out_q <= '0;
      dbz_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            dvd_q  <= dividend;
            dvs_q  <= divisor;
            rem_q  <= '0;
            quo_q  <= '0;
            cnt_q  <= CNT_W'(DVD_W - 1);
            busy_q <= 1'b1;
            if (divisor == '0) begin
              state_q   <= ST_DONE;
              done_q    <= 1'b1;
              quo_out_q <= '1;
              rem_out_q <= dividend[DVS_W-1:0];
              dbz_q     <= 1'b1;
            end else begin
              state_q <= ST_RUN;
            end
          end
        end
        ST_RUN: begin
          rem_q <= rem_d;
          quo_q <= {quo_q[DVD_W-2:0], qbit_d};
          dvd_q <= dvd_q << 1;
          cnt_q <= cnt_q - 1'b1;
          // The last iteration's result goes straight to the outputs on this edge.
          if (cnt_q == '0) begin
            state_q   <= ST_DONE;
            done_q    <= 1'b1;
            quo_out_q <= {quo_q[DVD_W-2:0], qbit_d};
            rem_out_q <= rem_d[DVS_W-1:0];
            dbz_q     <= 1'b0;
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign quotient  = quo_out_q;
  assign remainder = rem_out_q;
  assign dbz       = dbz_q;

endmodule

`default_nettype wire

// File: tb/tb_seq_divider.sv
// Scoreboard bench for seq_divider: reference results from plain / and %, checked on done.
`timescale 1ns/1ps
`default_nettype none

module tb_seq_divider;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic [15:0] dividend;
  logic [7:0]  divisor;
  logic        busy;
  logic        done;
  logic [15:0] quotient;
  logic [7:0]  remainder;
  logic        dbz;

  seq_divider #(.DVD_W(16), .DVS_W(8)) dut (
    .clock     (clock),
    .reset     (reset),
    .start     (start),
    .dividend  (dividend),
    .divisor   (divisor),
    .busy      (busy),
    .done      (done),
    .quotient  (quotient),
    .remainder (remainder),
    .dbz       (dbz)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [15:0] q;
    logic [7:0]  r;
    logic        z;
    int          lat;
    int          issued;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   cyc      = 0;
  int   n_checks = 0;
  int   n_pass   = 0;
  int   n_done   = 0;
  int   n_pushed = 0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_checks++;
    if (act === exp_v) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp_v, cyc);
  endtask

  function automatic exp_t model(input logic [15:0] a, input logic [7:0] b);
    exp_t e;
    if (b == 8'd0) begin
      e.q   = 16'hFFFF;
      e.r   = a[7:0];
      e.z   = 1'b1;
      e.lat = 1;
    end else begin
      e.q   = a / 16'(b);
      e.r   = 8'(a % 16'(b));
      e.z   = 1'b0;
      e.lat = 17;
    end
    e.issued = 0;
    return e;
  endfunction

  // Monitor: every done must match the oldest outstanding expectation.
  always @(negedge clock) begin
    if (done === 1'b1) begin
      n_done++;
      if (sb.size() == 0) begin
        chk("unexpected_done", 32'd1, 32'd0);
      end else begin
        mon_e = sb.pop_front();
        chk("quotient", 32'(quotient), 32'(mon_e.q));
        chk("remainder", 32'(remainder), 32'(mon_e.r));
        chk("dbz", 32'(dbz), 32'(mon_e.z));
        chk("latency", 32'(cyc - mon_e.issued), 32'(mon_e.lat));
      end
    end
  end

  task automatic wait_idle();
    int n = 0;
    while (busy !== 1'b0 && n < 200) begin
      @(negedge clock);
      n++;
    end
    if (n >= 200) chk("idle_timeout", 32'd1, 32'd0);
  endtask

  task automatic wait_drain();
    int n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(negedge clock);
      n++;
    end
    if (n >= 200) chk("drain_timeout", 32'd1, 32'd0);
  endtask

  task automatic issue(input logic [15:0] a, input logic [7:0] b, input bit push);
    exp_t e;
    wait_idle();
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    if (push) begin
      e        = model(a, b);
      e.issued = cyc;
      sb.push_back(e);
      n_pushed++;
    end
    @(negedge clock);
    start = 1'b0;
  endtask

  initial begin
    logic [15:0] ra;
    logic [7:0]  rb;
    int          done_before;

    reset    = 1'b1;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    repeat (3) @(negedge clock);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_quotient", 32'(quotient), 32'd0);
    chk("rst_remainder", 32'(remainder), 32'd0);
    chk("rst_dbz", 32'(dbz), 32'd0);
    reset = 1'b0;
    @(negedge clock);

    issue(16'd100, 8'd7, 1'b1);
    issue(16'hFFFF, 8'hFF, 1'b1);
    issue(16'd7, 8'd9, 1'b1);
    issue(16'h1234, 8'd0, 1'b1);
    issue(16'd65535, 8'd1, 1'b1);
    issue(16'd0, 8'd5, 1'b1);
    wait_drain();
    wait_idle();

    // Start coinciding with reset must be dropped.
    reset    = 1'b1;
    start    = 1'b1;
    dividend = 16'd100;
    divisor  = 8'd7;
    @(negedge clock);
    reset = 1'b0;
    start = 1'b0;
    chk("rst_start_busy0", 32'(busy), 32'd0);
    @(negedge clock);
    chk("rst_start_busy1", 32'(busy), 32'd0);

    // Second start during RUN is ignored: exactly one done carrying 100/7.
    done_before = n_done;
    issue(16'd100, 8'd7, 1'b1);
    repeat (3) @(negedge clock);
    dividend = 16'd50;
    divisor  = 8'd3;
    start    = 1'b1;
    @(negedge clock);
    start = 1'b0;
    wait_drain();
    repeat (4) @(negedge clock);
    chk("ignored_start_dones", 32'(n_done - done_before), 32'd1);

    // Mid-operation reset discards the running division.
    done_before = n_done;
    issue(16'd100, 8'd7, 1'b0);
    repeat (7) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_done", 32'(done), 32'd0);
    chk("midrst_quotient", 32'(quotient), 32'd0);
    chk("midrst_remainder", 32'(remainder), 32'd0);
    chk("midrst_dbz", 32'(dbz), 32'd0);
    repeat (20) @(negedge clock);
    chk("midrst_no_done", 32'(n_done - done_before), 32'd0);
    issue(16'd200, 8'd10, 1'b1);
    wait_drain();

    for (int i = 0; i < 1000; i++) begin
      case ($urandom_range(0, 9))
        0:       ra = 16'hFFFF;
        1:       ra = 16'h0000;
        default: ra = 16'($urandom_range(0, 65535));
      endcase
      case ($urandom_range(0, 9))
        0:       rb = 8'd1;
        1:       rb = 8'hFF;
        default: rb = 8'($urandom_range(1, 255));
      endcase
      issue(ra, rb, 1'b1);
    end
    wait_drain();
    repeat (4) @(negedge clock);
    chk("total_dones", 32'(n_done), 32'(n_pushed));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
